// File: rtl/hamming_rx_ctrl_if.sv
// Stream handshake bundle for the Hamming(7,4) receive controller:
// codeword input stream and decoded nibble output stream.
interface hamming_rx_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_syn;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_syn
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_syn
  );
endinterface

// File: rtl/hamming_rx_ctrl.sv
// Hamming(7,4) single-error-correcting receiver: one word in flight,
// IDLE -> CHECK -> (CORRECT) -> OUT, with saturating delivery statistics.
module hamming_rx_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_rx_ctrl_if.slave     bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     corr_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, CORRECT, OUT} state_t;

  state_t           state_q, state_d;
  logic [6:0]       word_q, word_d;
  logic [2:0]       syn_q, syn_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_data_q, out_data_d;
  logic [2:0]       out_syn_q, out_syn_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

  logic [2:0]       syn_calc;
  logic [6:0]       fixed_word;
  logic             deliver;

  // Syndrome points at the 1-based position of the flipped bit.
  always_comb begin
    syn_calc[0] = word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
    syn_calc[1] = word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
    syn_calc[2] = word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
    fixed_word  = word_q ^ (7'd1 << (syn_q - 3'd1));
  end

  assign deliver = (state_q == OUT) && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    syn_d       = syn_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_syn_d   = out_syn_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_code;
          state_d = CHECK;
        end
      end
      CHECK: begin
        syn_d = syn_calc;
        if (syn_calc == 3'd0) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = {word_q[6], word_q[5], word_q[4], word_q[2]};
          out_syn_d   = 3'd0;
        end else begin
          state_d = CORRECT;
        end
      end
      CORRECT: begin
        word_d      = fixed_word;
        state_d     = OUT;
        out_valid_d = 1'b1;
        out_data_d  = {fixed_word[6], fixed_word[5], fixed_word[4], fixed_word[2]};
        out_syn_d   = syn_q;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a same-cycle delivery; counters stick at all-ones.
  always_comb begin
    word_cnt_d = word_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (clr_stats) begin
      word_cnt_d = '0;
      corr_cnt_d = '0;
    end else if (deliver) begin
      if (word_cnt_q != {CNT_W{1'b1}})
        word_cnt_d = word_cnt_q + CNT_W'(1);
      if ((syn_q != 3'd0) && (corr_cnt_q != {CNT_W{1'b1}}))
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      syn_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_syn_q   <= '0;
      word_cnt_q  <= '0;
      corr_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      syn_q       <= syn_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_syn_q   <= out_syn_d;
      word_cnt_q  <= word_cnt_d;
      corr_cnt_q  <= corr_cnt_d;
    end
  end

  // Ready is a pure state decode, masked so it stays low throughout reset.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_syn   = out_syn_q;
  assign word_cnt      = word_cnt_q;
  assign corr_cnt      = corr_cnt_q;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Self-checking bench for hamming_rx_ctrl: a position-XOR Hamming model and
// handshake timing model checked every cycle, plus directed literal checks.
module tb_hamming_rx_ctrl;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] corr_cnt;

  int checks = 0;
  int errors = 0;

  hamming_rx_ctrl_if bus ();

  hamming_rx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_stats (clr_stats),
    .word_cnt  (word_cnt),
    .corr_cnt  (corr_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Syndrome as XOR of 1-based positions of all set bits.
  function automatic logic [2:0] modelSyn(input logic [6:0] c);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 7; i++)
      if (c[i]) s = s ^ 3'(i + 1);
    return s;
  endfunction

  function automatic logic [3:0] modelData(input logic [6:0] c);
    logic [6:0] f;
    logic [2:0] s;
    s = modelSyn(c);
    f = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    return {f[6], f[5], f[4], f[2]};
  endfunction

  function automatic int satInc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Behavioural model state
  bit         busy = 1'b0;
  int         age = 0;
  int         lat = 0;
  int         mWord = 0;
  int         mCorr = 0;
  logic [3:0] eData = 4'd0;
  logic [2:0] eSyn = 3'd0;

  always @(negedge clk) begin : compare
    bit expOv;
    bit hsOut;
    bit accept;
    if (rst) begin
      checkOutput("rst_in_ready", int'(bus.in_ready), 0);
      checkOutput("rst_out_valid", int'(bus.out_valid), 0);
      checkOutput("rst_out_data", int'(bus.out_data), 0);
      checkOutput("rst_out_syn", int'(bus.out_syn), 0);
      checkOutput("rst_word_cnt", int'(word_cnt), 0);
      checkOutput("rst_corr_cnt", int'(corr_cnt), 0);
      busy  = 1'b0;
      mWord = 0;
      mCorr = 0;
    end else begin
      expOv = busy && (age >= lat);
      checkOutput("m_in_ready", int'(bus.in_ready), int'(!busy));
      checkOutput("m_out_valid", int'(bus.out_valid), int'(expOv));
      checkOutput("m_word_cnt", int'(word_cnt), mWord);
      checkOutput("m_corr_cnt", int'(corr_cnt), mCorr);
      if (expOv) begin
        checkOutput("m_out_data", int'(bus.out_data), int'(eData));
        checkOutput("m_out_syn", int'(bus.out_syn), int'(eSyn));
      end
      accept = !busy && bus.in_valid;
      hsOut  = expOv && bus.out_ready;
      if (clr_stats) begin
        mWord = 0;
        mCorr = 0;
      end else if (hsOut) begin
        mWord = satInc(mWord);
        if (eSyn != 3'd0) mCorr = satInc(mCorr);
      end
      if (hsOut) busy = 1'b0;
      else if (busy) age++;
      if (accept) begin
        busy  = 1'b1;
        age   = 1;
        eSyn  = modelSyn(bus.in_code);
        eData = modelData(bus.in_code);
        lat   = (eSyn != 3'd0) ? 3 : 2;
      end
    end
  end

  // Offer one word, check data/syndrome/latency, optionally hold out_ready low.
  task automatic applyStimulus(input logic [6:0] code, input logic [3:0] expData,
                               input logic [2:0] expSyn, input int expLat,
                               input int holdCycles, input bit clrAtHs);
    int cyc;
    int w0;
    bit got;
    logic [3:0] d0;
    logic [2:0] s0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_code   = code;
    bus.out_ready = (holdCycles == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) checkOutput("out_valid_timeout", 0, 1);
    checkOutput("latency", cyc, expLat);
    checkOutput("lit_out_data", int'(bus.out_data), int'(expData));
    checkOutput("lit_out_syn", int'(bus.out_syn), int'(expSyn));
    if (holdCycles > 0) begin
      d0 = bus.out_data;
      s0 = bus.out_syn;
      w0 = int'(word_cnt);
      repeat (holdCycles) begin
        @(negedge clk);
        checkOutput("hold_out_valid", int'(bus.out_valid), 1);
        checkOutput("hold_out_data", int'(bus.out_data), int'(d0));
        checkOutput("hold_out_syn", int'(bus.out_syn), int'(s0));
        checkOutput("hold_in_ready", int'(bus.in_ready), 0);
        checkOutput("hold_word_cnt", int'(word_cnt), w0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      clr_stats = clrAtHs;
      @(posedge clk); #1;
      clr_stats = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!bus.out_valid) got = 1'b1;
    end
    if (!got) checkOutput("handshake_timeout", 0, 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = 7'd0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("pin_model_data_55", int'(modelData(7'h55)), 4'hB);
    checkOutput("pin_model_syn_55", int'(modelSyn(7'h55)), 0);
    checkOutput("pin_model_syn_45", int'(modelSyn(7'h45)), 5);
    checkOutput("pin_model_data_45", int'(modelData(7'h45)), 4'hB);
    checkOutput("pin_model_syn_54", int'(modelSyn(7'h54)), 1);

    applyStimulus(7'h55, 4'hB, 3'd0, 2, 0, 1'b0);
    checkOutput("clean_word_cnt", int'(word_cnt), 1);
    checkOutput("clean_corr_cnt", int'(corr_cnt), 0);

    applyStimulus(7'h45, 4'hB, 3'd5, 3, 0, 1'b0);
    checkOutput("d1err_word_cnt", int'(word_cnt), 2);
    checkOutput("d1err_corr_cnt", int'(corr_cnt), 1);

    applyStimulus(7'h54, 4'hB, 3'd1, 3, 0, 1'b0);
    checkOutput("p1err_corr_cnt", int'(corr_cnt), 2);

    for (int i = 0; i < 7; i++)
      applyStimulus(7'h55 ^ (7'd1 << i), 4'hB, 3'(i + 1), 3, 0, 1'b0);
    checkOutput("sweep_word_cnt_sat", int'(word_cnt), 3);
    checkOutput("sweep_corr_cnt_sat", int'(corr_cnt), 3);

    @(posedge clk); #1 clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
    @(negedge clk);
    checkOutput("clr_word_cnt", int'(word_cnt), 0);
    checkOutput("clr_corr_cnt", int'(corr_cnt), 0);

    applyStimulus(7'h55, 4'hB, 3'd0, 2, 10, 1'b0);
    checkOutput("bp_word_cnt", int'(word_cnt), 1);
    checkOutput("bp_corr_cnt", int'(corr_cnt), 0);

    for (int k = 0; k < 5; k++)
      applyStimulus(7'h55 ^ (7'd1 << k), 4'hB, 3'(k + 1), 3, 0, 1'b0);
    checkOutput("sat_word_cnt", int'(word_cnt), 3);
    checkOutput("sat_corr_cnt", int'(corr_cnt), 3);

    applyStimulus(7'h45, 4'hB, 3'd5, 3, 2, 1'b1);
    checkOutput("clr_hs_word_cnt", int'(word_cnt), 0);
    checkOutput("clr_hs_corr_cnt", int'(corr_cnt), 0);

    applyStimulus(7'h45, 4'hB, 3'd5, 3, 0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_code  = 7'h45;
    @(negedge clk);
    checkOutput("rmid_accept", int'(bus.in_ready), 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkOutput("rmid_out_valid", int'(bus.out_valid), 0);
    checkOutput("rmid_out_data", int'(bus.out_data), 0);
    checkOutput("rmid_out_syn", int'(bus.out_syn), 0);
    checkOutput("rmid_in_ready", int'(bus.in_ready), 0);
    checkOutput("rmid_word_cnt", int'(word_cnt), 0);
    checkOutput("rmid_corr_cnt", int'(corr_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_in_ready", int'(bus.in_ready), 1);
    checkOutput("rel_word_cnt", int'(word_cnt), 0);

    applyStimulus(7'h55, 4'hB, 3'd0, 2, 0, 1'b0);
    checkOutput("final_word_cnt", int'(word_cnt), 1);
    checkOutput("final_corr_cnt", int'(corr_cnt), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
